// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer: channel ids,
// steering modes, probe bus layout and the effective-target rule.
package demux_pkg;

  // Channel identifiers, used as the value of the effective target.
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // Steering modes: explicit steer by sel, or alternate on every accept.
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_ALT = 1'b1;

  // Debug probe bus layout.
  localparam int PROBE_W      = 9;
  localparam int PRB_DATA0    = 0;  // in_data[0]
  localparam int PRB_SEL      = 1;  // sel
  localparam int PRB_TGT      = 2;  // effective target
  localparam int PRB_TGT_N    = 3;  // inverted effective target
  localparam int PRB_TOGGLE   = 4;  // auto-alternate toggle register
  localparam int PRB_FULL0    = 5;  // FIFO 0 full
  localparam int PRB_FULL1    = 6;  // FIFO 1 full
  localparam int PRB_ACCEPT0  = 7;  // word accepted into FIFO 0
  localparam int PRB_ACCEPT1  = 8;  // word accepted into FIFO 1

  // Effective steer target: the toggle in auto-alternate mode, sel otherwise.
  function automatic logic eff_target(input logic mode, input logic sel,
                                      input logic toggle);
    return (mode == MODE_ALT) ? toggle : sel;
  endfunction

endpackage

// File: rtl/demux_fifo.sv
// Small synchronous FIFO for one output channel of the demultiplexer.
// The head word is presented combinationally; a push while full and a pop
// while empty are ignored. Head data reads as zero whenever the FIFO is empty.
module demux_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  // Advance a pointer, wrapping modulo DEPTH.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy registers; reset empties the FIFO.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array written on an accepted push.
  // NOTE: the array carries no reset; stale entries are unreachable because
  // the pointers and count are reset and rdata is forced to zero when empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/demux_1to2_stream.sv
// Registered 1-to-2 stream demultiplexer. One input channel is steered to
// one of two buffered output channels, either by sel or by an alternating
// toggle. Each output has its own FIFO so a stalled consumer blocks only
// its own path. A 9-bit probe exposes the steering internals.
module demux_1to2_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               sel,
  input  logic               mode,
  output logic [WIDTH-1:0]   out0_data,
  output logic               out0_valid,
  input  logic               out0_ready,
  output logic [WIDTH-1:0]   out1_data,
  output logic               out1_valid,
  input  logic               out1_ready,
  output logic [PROBE_W-1:0] probe
);

  logic               toggle;
  logic               tgt;
  logic               accept;
  logic               push0;
  logic               push1;
  logic               full0;
  logic               full1;
  logic               empty0;
  logic               empty1;
  logic [$clog2(DEPTH):0] count0;
  logic [$clog2(DEPTH):0] count1;

  // Steering, handshake and probe decode from the current inputs and state.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    tgt      = eff_target(mode, sel, toggle);
    in_ready = 1'b0;
    push0    = 1'b0;
    push1    = 1'b0;
    probe    = '0;

    // A full target stalls the input even if that FIFO pops this cycle.
    in_ready = (tgt == CH1) ? ~full1 : ~full0;
    accept   = in_valid & in_ready;
    push0    = accept & (tgt == CH0);
    push1    = accept & (tgt == CH1);

    probe[PRB_DATA0]   = in_data[0];
    probe[PRB_SEL]     = sel;
    probe[PRB_TGT]     = tgt;
    probe[PRB_TGT_N]   = ~tgt;
    probe[PRB_TOGGLE]  = toggle;
    probe[PRB_FULL0]   = full0;
    probe[PRB_FULL1]   = full1;
    probe[PRB_ACCEPT0] = push0;
    probe[PRB_ACCEPT1] = push1;
  end

  // Alternation toggle: flips only on an accepted word in auto-alternate mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle <= 1'b0;
    end else if (accept && (mode == MODE_ALT)) begin
      toggle <= ~toggle;
    end
  end

  demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (push0),
    .wdata (in_data),
    .pop   (out0_ready),
    .rdata (out0_data),
    .full  (full0),
    .empty (empty0),
    .count (count0)
  );

  demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1),
    .wdata (in_data),
    .pop   (out1_ready),
    .rdata (out1_data),
    .full  (full1),
    .empty (empty1),
    .count (count1)
  );

  assign out0_valid = ~empty0;
  assign out1_valid = ~empty1;

  // Occupancy counts are not needed by the steering logic.
  logic unused_counts;
  assign unused_counts = ^{count0, count1};

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Self-checking bench for demux_1to2_stream: a queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_demux_1to2_stream;
  import demux_pkg::*;

  localparam int W = 8;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         sel;
  logic         mode;
  logic [W-1:0] out0_data;
  logic         out0_valid;
  logic         out0_ready;
  logic [W-1:0] out1_data;
  logic         out1_valid;
  logic         out1_ready;
  logic [PROBE_W-1:0] probe;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  demux_1to2_stream #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sel        (sel),
    .mode       (mode),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .probe      (probe)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue of pending words per channel and the toggle.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic         m_tog;

  always @(posedge clk or posedge rst) begin
    logic t, rdy, acc, p0, p1;
    if (rst) begin
      q0.delete();
      q1.delete();
      m_tog = 1'b0;
    end else begin
      t   = mode ? m_tog : sel;
      rdy = t ? (q1.size() < D) : (q0.size() < D);
      acc = in_valid & rdy;
      p0  = out0_ready && (q0.size() > 0);
      p1  = out1_ready && (q1.size() > 0);
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (acc) begin
        if (t) q1.push_back(in_data);
        else   q0.push_back(in_data);
        if (mode) m_tog = ~m_tog;
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    logic         t, rdy, acc, f0, f1;
    logic [W-1:0] h0, h1;
    logic [PROBE_W-1:0] ep;
    if (cmp_en) begin
      t   = mode ? m_tog : sel;
      f0  = (q0.size() == D);
      f1  = (q1.size() == D);
      rdy = t ? ~f1 : ~f0;
      acc = in_valid & rdy;
      h0  = (q0.size() > 0) ? q0[0] : '0;
      h1  = (q1.size() > 0) ? q1[0] : '0;
      ep  = {acc & t, acc & ~t, f1, f0, m_tog, ~t, t, sel, in_data[0]};
      check("cmp in_ready",   32'(in_ready),   32'(rdy));
      check("cmp out0_valid", 32'(out0_valid), 32'(q0.size() > 0));
      check("cmp out0_data",  32'(out0_data),  32'(h0));
      check("cmp out1_valid", 32'(out1_valid), 32'(q1.size() > 0));
      check("cmp out1_data",  32'(out1_data),  32'(h1));
      check("cmp probe",      32'(probe),      32'(ep));
    end
  end

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    in_data    = '0;
    in_valid   = 1'b0;
    sel        = 1'b0;
    mode       = MODE_SEL;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    cyc();
    cmp_en = 1'b1;

    // Reset state.
    check("rst out0_valid", 32'(out0_valid), 32'd0);
    check("rst out1_valid", 32'(out1_valid), 32'd0);
    check("rst out0_data",  32'(out0_data),  32'd0);
    check("rst out1_data",  32'(out1_data),  32'd0);
    check("rst in_ready",   32'(in_ready),   32'd1);
    check("rst toggle",     32'(probe[PRB_TOGGLE]), 32'd0);

    // Single word steered to out0, latency one cycle.
    mode = MODE_SEL; sel = CH0; out0_ready = 1'b1; out1_ready = 1'b1;
    in_data = 8'd1; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("t1 out0_valid", 32'(out0_valid), 32'd1);
    check("t1 out0_data",  32'(out0_data),  32'd1);
    check("t1 out1_valid", 32'(out1_valid), 32'd0);
    cyc();
    check("t1 out0 drained", 32'(out0_valid), 32'd0);

    // Auto-alternate: 1,0,1,0 -> out0 gets 1,1 and out1 gets 0,0.
    mode = MODE_ALT; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = (i % 2 == 0) ? 8'd1 : 8'd0;
      cyc();
      if (i % 2 == 0) begin
        check("t2 out0_valid", 32'(out0_valid), 32'd1);
        check("t2 out0_data",  32'(out0_data),  32'd1);
      end else begin
        check("t2 out1_valid", 32'(out1_valid), 32'd1);
        check("t2 out1_data",  32'(out1_data),  32'd0);
      end
    end
    in_valid = 1'b0;
    check("t2 toggle end", 32'(probe[PRB_TOGGLE]), 32'd0);
    cyc();

    // Fill FIFO 1, stall, then pop without bypass.
    mode = MODE_SEL; sel = CH1; out1_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'hA1; cyc();
    in_data = 8'hA2; cyc();
    in_data = 8'hA3; #1;
    check("t3 in_ready full", 32'(in_ready),        32'd0);
    check("t3 probe full1",   32'(probe[PRB_FULL1]), 32'd1);
    check("t3 out1 head",     32'(out1_data),        32'hA1);
    check("t3 model depth",   32'(q1.size()),        32'd2);
    cyc();
    check("t3 still stalled", 32'(in_ready),  32'd0);
    check("t3 head held",     32'(out1_data), 32'hA1);
    out1_ready = 1'b1; #1;
    check("t3 no bypass",     32'(in_ready),  32'd0);
    cyc();
    check("t3 popped head",   32'(out1_data), 32'hA2);
    check("t3 ready again",   32'(in_ready),  32'd1);
    cyc();
    check("t3 retried word",  32'(out1_data), 32'hA3);
    in_valid = 1'b0;
    cyc();
    check("t3 drained",       32'(out1_valid), 32'd0);

    // Stalled on full FIFO 1, switch sel to 0: word lands in out0.
    out0_ready = 1'b0; out1_ready = 1'b0; sel = CH1; in_valid = 1'b1;
    in_data = 8'hB1; cyc();
    in_data = 8'hB2; cyc();
    in_data = 8'hB3; #1;
    check("t4 stalled", 32'(in_ready), 32'd0);
    sel = CH0; #1;
    check("t4 resteer ready", 32'(in_ready), 32'd1);
    check("t4 probe tgt",     32'(probe[PRB_TGT]), 32'd0);
    cyc();
    in_valid = 1'b0;
    check("t4 out0_valid", 32'(out0_valid), 32'd1);
    check("t4 out0_data",  32'(out0_data),  32'hB3);
    check("t4 out1_data",  32'(out1_data),  32'hB1);

    // Two words in each FIFO with toggle=1, then asynchronous reset.
    mode = MODE_ALT; in_valid = 1'b1; in_data = 8'hB4;
    cyc();
    in_valid = 1'b0;
    check("t5 toggle set", 32'(probe[PRB_TOGGLE]), 32'd1);
    check("t5 full0",      32'(probe[PRB_FULL0]),  32'd1);
    check("t5 full1",      32'(probe[PRB_FULL1]),  32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5 async out0_valid", 32'(out0_valid), 32'd0);
    check("t5 async out1_valid", 32'(out1_valid), 32'd0);
    check("t5 async out0_data",  32'(out0_data),  32'd0);
    check("t5 async out1_data",  32'(out1_data),  32'd0);
    cyc();
    cyc();
    #2 rst = 1'b0;
    cyc();
    check("t5 post in_ready", 32'(in_ready),           32'd1);
    check("t5 post toggle",   32'(probe[PRB_TOGGLE]),   32'd0);
    check("t5 post valid0",   32'(out0_valid),          32'd0);
    check("t5 post valid1",   32'(out1_valid),          32'd0);

    // Random traffic; the per-cycle compare acts as the scoreboard.
    for (int n = 0; n < 10000; n++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      in_data    = W'($urandom);
      sel        = 1'($urandom);
      out0_ready = ($urandom_range(0, 9) < 6);
      out1_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 31) == 0) mode = ~mode;
      cyc();
    end
    in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
    repeat (4) cyc();
    check("t6 drained out0",  32'(out0_valid), 32'd0);
    check("t6 drained out1",  32'(out1_valid), 32'd0);
    check("t6 model empty",   32'(q0.size() + q1.size()), 32'd0);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
